sw_debouncer: RTL and testbench



---
 rtl/sw_debouncer_pkg.sv | 22 ++
 rtl/sw_debounce_bit.sv | 64 ++++++
 rtl/sw_debouncer.sv | 62 ++++++
 tb/tb_sw_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_debouncer_pkg.sv
// rtl/sw_debouncer_pkg.sv - shared defaults, event encoding and helpers for the switch debouncer
`timescale 1ns/1ps

package sw_debouncer_pkg;

    localparam int SW_WIDTH             = 10;
    localparam int SW_CNT_W             = 16;
    localparam int SW_STABLE_CYCLES_HW  = 50000;
    localparam int SW_STABLE_CYCLES_SIM = 4;
    localparam int SW_EVT_CNT_W         = 8;

    typedef enum logic [1:0] {
        SW_EDGE_NONE = 2'b00,
        SW_EDGE_RISE = 2'b01,
        SW_EDGE_FALL = 2'b10
    } sw_edge_e;

    function automatic logic [SW_EVT_CNT_W-1:0] sw_evt_sat_inc(input logic [SW_EVT_CNT_W-1:0] v);
        return (v == {SW_EVT_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch bit: 2-flop synchroniser, stability counter, accepted level and edge pulses
`timescale 1ns/1ps

module sw_debounce_bit
    import sw_debouncer_pkg::*;
#(
    parameter int CNT_W         = SW_CNT_W,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_HW
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    sw_edge_e         evt_q;
    sw_edge_e         evt_d;

    // Any cycle where s2 matches the accepted level restarts the count, so glitches never accumulate.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        evt_d    = SW_EDGE_NONE;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                evt_d    = s2_q ? SW_EDGE_RISE : SW_EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            evt_q    <= SW_EDGE_NONE;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
        end
    end

    assign sw_o   = stable_q;
    assign rise_o = (evt_q == SW_EDGE_RISE);
    assign fall_o = (evt_q == SW_EDGE_FALL);

endmodule

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - debounced switch bus with rise/fall pulses; SW_DEBOUNCER_EVT_CNT_EN adds io_evt_cnt
`timescale 1ns/1ps

module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int CNT_W         = SW_CNT_W,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_HW
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        io_sw_raw,
    output logic [WIDTH-1:0]        io_sw,
    output logic [WIDTH-1:0]        io_sw_rise,
    output logic [WIDTH-1:0]        io_sw_fall
`ifdef SW_DEBOUNCER_EVT_CNT_EN
    ,
    output logic [SW_EVT_CNT_W-1:0] io_evt_cnt
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk_i (clock),
            .rst_i (reset),
            .raw_i (io_sw_raw[i]),
            .sw_o  (io_sw[i]),
            .rise_o(io_sw_rise[i]),
            .fall_o(io_sw_fall[i])
        );
    end

`ifdef SW_DEBOUNCER_EVT_CNT_EN
    logic [SW_EVT_CNT_W-1:0] evt_cnt_q;
    logic [SW_EVT_CNT_W-1:0] evt_cnt_d;

    // One count per pulse cycle however many bits fire together; holds at full scale.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (|(io_sw_rise | io_sw_fall)) begin
            evt_cnt_d = sw_evt_sat_inc(evt_cnt_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign io_evt_cnt = evt_cnt_q;
`else
    // Without the event counter only the per-bit outputs exist.
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
// tb/tb_sw_debouncer.sv - directed bench with a windowed behavioural model of the switch debouncer
`timescale 1ns/1ps

module tb_sw_debouncer;
    import sw_debouncer_pkg::*;

    localparam int W = SW_WIDTH;
    localparam int S = SW_STABLE_CYCLES_SIM;

    logic         clock     = 1'b0;
    logic         reset     = 1'b0;
    logic [W-1:0] io_sw_raw = '0;
    logic [W-1:0] io_sw;
    logic [W-1:0] io_sw_rise;
    logic [W-1:0] io_sw_fall;
`ifdef SW_DEBOUNCER_EVT_CNT_EN
    logic [SW_EVT_CNT_W-1:0] io_evt_cnt;
`endif

    int tests  = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    sw_debouncer #(
        .WIDTH        (W),
        .CNT_W        (SW_CNT_W),
        .STABLE_CYCLES(S)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_sw_raw (io_sw_raw),
        .io_sw     (io_sw),
        .io_sw_rise(io_sw_rise),
        .io_sw_fall(io_sw_fall)
`ifdef SW_DEBOUNCER_EVT_CNT_EN
        ,
        .io_evt_cnt(io_evt_cnt)
`endif
    );

    // Model: a bit is accepted when the last S synchronised samples all disagree with its accepted level.
    logic [W-1:0] m_sw   = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    int           m_evt  = 0;
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] s2_hist[$];

    always @(posedge clock or posedge reset) begin : model
        logic [W-1:0] s2v;
        logic [W-1:0] acc;
        bit           all_diff;
        if (reset) begin
            m_sw   = '0;
            m_rise = '0;
            m_fall = '0;
            m_evt  = 0;
            raw_hist.delete();
            s2_hist.delete();
        end else begin
            if ((|(m_rise | m_fall)) && m_evt < 255) m_evt++;
            s2v = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
            raw_hist.push_back(io_sw_raw);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            s2_hist.push_back(s2v);
            if (s2_hist.size() > S) void'(s2_hist.pop_front());
            acc = '0;
            if (s2_hist.size() == S) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < S; k++) begin
                        if (s2_hist[k][b] == m_sw[b]) all_diff = 1'b0;
                    end
                    acc[b] = all_diff;
                end
            end
            m_rise = acc & ~m_sw;
            m_fall = acc & m_sw;
            m_sw   = m_sw ^ acc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && chk_en) begin
            check("model_sw",   32'(io_sw),      32'(m_sw));
            check("model_rise", 32'(io_sw_rise), 32'(m_rise));
            check("model_fall", 32'(io_sw_fall), 32'(m_fall));
`ifdef SW_DEBOUNCER_EVT_CNT_EN
            check("model_evt",  32'(io_evt_cnt), 32'(m_evt));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("por_sw",   32'(io_sw),      0);
        check("por_rise", 32'(io_sw_rise), 0);
        check("por_fall", 32'(io_sw_fall), 0);
        tick(2);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Async reset mid-cycle with all switches high, then acceptance after release
        io_sw_raw = 10'h3FF;
        tick(8);
        check("pre_rst_sw", 32'(io_sw), 'h3FF);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sw",   32'(io_sw),      0);
        check("async_rst_rise", 32'(io_sw_rise), 0);
        check("async_rst_fall", 32'(io_sw_fall), 0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("rel_sw_early", 32'(io_sw), 0);
        tick(1);
        check("rel_sw",   32'(io_sw),      'h3FF);
        check("rel_rise", 32'(io_sw_rise), 'h3FF);
        tick(1);
        check("rel_rise_gone", 32'(io_sw_rise), 0);

        // Clean step on bit 2
        io_sw_raw = 10'h000;
        tick(8);
        check("clr_sw", 32'(io_sw), 0);
        io_sw_raw = 10'h004;
        tick(5);
        check("step_sw_early", 32'(io_sw), 0);
        tick(1);
        check("step_sw",   32'(io_sw),      'h004);
        check("step_rise", 32'(io_sw_rise), 'h004);
        check("step_fall", 32'(io_sw_fall), 0);
        tick(1);
        check("step_rise_gone", 32'(io_sw_rise), 0);

        // Bounce on bit 0 before settling high
        io_sw_raw = 10'h005; tick(1);
        io_sw_raw = 10'h004; tick(1);
        io_sw_raw = 10'h005; tick(1);
        io_sw_raw = 10'h004; tick(1);
        io_sw_raw = 10'h005;
        tick(5);
        check("bounce_sw_early", 32'(io_sw), 'h004);
        tick(1);
        check("bounce_sw",   32'(io_sw),      'h005);
        check("bounce_rise", 32'(io_sw_rise), 'h001);

        // Simultaneous rise and fall on several bits
        io_sw_raw = 10'h0F0;
        tick(8);
        check("sim_pre_sw", 32'(io_sw), 'h0F0);
        io_sw_raw = 10'h30F;
        tick(5);
        check("sim_sw_early", 32'(io_sw), 'h0F0);
        tick(1);
        check("sim_sw",   32'(io_sw),      'h30F);
        check("sim_rise", 32'(io_sw_rise), 'h30F);
        check("sim_fall", 32'(io_sw_fall), 'h0F0);
        tick(1);
        check("sim_pulse_gone", 32'(io_sw_rise | io_sw_fall), 0);

        // Glitch on bit 9 shorter than the stability window
        io_sw_raw = 10'h000;
        tick(8);
        io_sw_raw = 10'h200;
        tick(3);
        io_sw_raw = 10'h000;
        tick(10);
        check("glitch_sw", 32'(io_sw), 0);

        // Reset in the middle of a count discards progress
        io_sw_raw = 10'h001;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        check("midrst_sw_early", 32'(io_sw), 0);
        tick(1);
        check("midrst_sw",   32'(io_sw),      'h001);
        check("midrst_rise", 32'(io_sw_rise), 'h001);

`ifdef SW_DEBOUNCER_EVT_CNT_EN
        for (int i = 0; i < 300; i++) begin
            io_sw_raw = io_sw_raw ^ 10'h002;
            tick(6);
        end
        tick(2);
        check("evt_sat", 32'(io_evt_cnt), 255);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
